// File: rtl/isquare_iter.sv
// Iterative unsigned squarer: one shift-and-add step per cycle, LSB first,
// behind a valid/ready handshake on both sides.
module isquare_iter #(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ivld,
    input  logic [W-1:0]   ix,
    output logic           irdy,
    output logic           ovld,
    input  logic           ordy,
    output logic [2*W-1:0] oy
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   x_q, x_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [2*W-1:0] oy_q, oy_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*W-1:0] pp;
    logic [2*W-1:0] sum;

    // Partial product for the multiplier bit selected by the counter.
    always_comb begin
        pp  = x_q[cnt_q] ? ({{W{1'b0}}, x_q} << cnt_q) : '0;
        sum = acc_q + pp;
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        oy_d    = oy_q;
        case (state_q)
            S_IDLE: begin
                if (ivld) begin
                    x_d     = ix;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                // The last bit's sum goes straight to oy; the counter never wraps.
                if (cnt_q == CNT_LAST) begin
                    oy_d    = sum;
                    state_d = S_DONE;
                end else begin
                    acc_d = sum;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (ordy) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            oy_q    <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            oy_q    <= oy_d;
        end
    end

    assign irdy = (state_q == S_IDLE);
    assign ovld = (state_q == S_DONE);
    assign oy   = oy_q;

endmodule
